hack_alu_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's combinational Hack ALU.
- Keeps the Hack control set (zx, nx, zy, ny, f, no) and generalises the datapath to WIDTH bits.
- Adds a two-stage elastic valid/ready pipeline, registered status flags (zr, ng, carry, overflow) and a completed-operation counter.
- Sits between the register file/decoder and the writeback path of the CPU datapath.

---
 rtl/hack_alu_pkg.sv | 20 ++
 rtl/hack_alu_core.sv | 78 +++++++
 rtl/hack_alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_hack_alu_pipe.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared definitions for the pipelined Hack ALU: control bit positions and
// the named control words used by the decoder and the bench.
package hack_alu_pkg;

    localparam int CTRL_W = 6;

    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    localparam logic [CTRL_W-1:0] ADD    = 6'b000010;
    localparam logic [CTRL_W-1:0] SUB_XY = 6'b010011;
    localparam logic [CTRL_W-1:0] AND    = 6'b000000;
    localparam logic [CTRL_W-1:0] ZERO   = 6'b101010;
    localparam logic [CTRL_W-1:0] ONE    = 6'b111111;

endpackage

// File: rtl/hack_alu_core.sv
// Hack ALU split at the x2/y2 boundary: operand preprocessing (zero/negate)
// feeds stage 1, the add/and function with output negation feeds stage 2.
module hack_alu_pre
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  x2,
    output logic [WIDTH-1:0]  y2
);

    logic [WIDTH-1:0] x1_s;
    logic [WIDTH-1:0] y1_s;

    // Zero then optionally invert each operand.
    always_comb begin
        if (ctrl[ZX]) begin
            x1_s = {WIDTH{1'b0}};
        end else begin
            x1_s = x;
        end
        if (ctrl[NX]) begin
            x2 = ~x1_s;
        end else begin
            x2 = x1_s;
        end
        if (ctrl[ZY]) begin
            y1_s = {WIDTH{1'b0}};
        end else begin
            y1_s = y;
        end
        if (ctrl[NY]) begin
            y2 = ~y1_s;
        end else begin
            y2 = y1_s;
        end
    end

endmodule

module hack_alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] r_s;

    // Carry and overflow come from the raw sum, before the output inversion.
    always_comb begin
        sum_s = {1'b0, x2} + {1'b0, y2};
        if (f) begin
            r_s      = sum_s[WIDTH-1:0];
            carry    = sum_s[WIDTH];
            overflow = (x2[WIDTH-1] == y2[WIDTH-1]) && (sum_s[WIDTH-1] != x2[WIDTH-1]);
        end else begin
            r_s      = x2 & y2;
            carry    = 1'b0;
            overflow = 1'b0;
        end
        if (no) begin
            result = ~r_s;
        end else begin
            result = r_s;
        end
    end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage elastic Hack ALU: s1 holds preprocessed operands, s2 holds the
// result and status flags; op_count tallies results taken downstream.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  X,
    input  logic [WIDTH-1:0]  Y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out,
    output logic              zr,
    output logic              ng,
    output logic              carry_out,
    output logic              overflow,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x2_q, s1_x2_d;
    logic [WIDTH-1:0] s1_y2_q, s1_y2_d;
    logic             s1_f_q, s1_f_d;
    logic             s1_no_q, s1_no_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             s1_adv_s;
    logic             s2_adv_s;
    logic [WIDTH-1:0] x2_s;
    logic [WIDTH-1:0] y2_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;

    hack_alu_pre #(.WIDTH(WIDTH)) u_pre (
        .x    (X),
        .y    (Y),
        .ctrl (ctrl),
        .x2   (x2_s),
        .y2   (y2_s)
    );

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .x2       (s1_x2_q),
        .y2       (s1_y2_q),
        .f        (s1_f_q),
        .no       (s1_no_q),
        .result   (res_s),
        .carry    (carry_s),
        .overflow (ovf_s)
    );

    // Backpressure ripples from the output; in_valid never feeds in_ready.
    assign s2_adv_s = !s2_valid_q || out_ready;
    assign s1_adv_s = !s1_valid_q || s2_adv_s;

    // Next-state for both stages and the completion counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x2_d    = s1_x2_q;
        s1_y2_d    = s1_y2_q;
        s1_f_d     = s1_f_q;
        s1_no_d    = s1_no_q;
        s2_valid_d = s2_valid_q;
        out_d      = out_q;
        zr_d       = zr_q;
        ng_d       = ng_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        op_count_d = op_count_q;

        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = res_s;
                zr_d    = (res_s == {WIDTH{1'b0}});
                ng_d    = res_s[WIDTH-1];
                carry_d = carry_s;
                ovf_d   = ovf_s;
            end else begin
                out_d   = out_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x2_d = x2_s;
                s1_y2_d = y2_s;
                s1_f_d  = ctrl[F];
                s1_no_d = ctrl[NO];
            end else begin
                s1_x2_d = s1_x2_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_valid_q && out_ready) begin
            op_count_d = op_count_q + CNT_ONE;
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Pipeline state; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x2_q    <= {WIDTH{1'b0}};
            s1_y2_q    <= {WIDTH{1'b0}};
            s1_f_q     <= 1'b0;
            s1_no_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            out_q      <= {WIDTH{1'b0}};
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            op_count_q <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x2_q    <= s1_x2_d;
            s1_y2_q    <= s1_y2_d;
            s1_f_q     <= s1_f_d;
            s1_no_q    <= s1_no_d;
            s2_valid_q <= s2_valid_d;
            out_q      <= out_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            op_count_q <= op_count_d;
        end
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Directed bench for hack_alu_pipe: arithmetic vectors, stall/backpressure
// ordering and asynchronous reset with both stages full.
module tb_hack_alu_pipe;
    import hack_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic [5:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        carry_out;
    logic        overflow;
    logic [31:0] op_count;

    int checks;
    int errors;
    int exp_cnt;

    hack_alu_pipe #(.WIDTH(16), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .carry_out (carry_out),
        .overflow  (overflow),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) break;
            @(negedge clk);
        end
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] c, input logic [15:0] eo, input logic ez,
                          input logic en, input logic ec, input logic ev);
        @(negedge clk);
        X = x; Y = y; ctrl = c; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_not_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        wait_valid(tag);
        chk({tag, "_out"}, {16'd0, out}, {16'd0, eo});
        chk({tag, "_zr"}, {31'd0, zr}, {31'd0, ez});
        chk({tag, "_ng"}, {31'd0, ng}, {31'd0, en});
        chk({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ev});
        @(negedge clk);
        exp_cnt++;
        chk({tag, "_op_count"}, op_count, exp_cnt);
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        X = 16'd0; Y = 16'd0; ctrl = 6'd0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic vectors: tag, X, Y, ctrl, out, zr, ng, carry, overflow
        run_op("add_5_3",   16'd5,      16'd3,      ADD,    16'd8,      1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_5_3",   16'd5,      16'd3,      SUB_XY, 16'd2,      1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",   16'd3,      16'd5,      SUB_XY, 16'hFFFE,   1'b0, 1'b1, 1'b1, 1'b0);
        run_op("add_wrap",  16'hFFFF,   16'd1,      ADD,    16'h0000,   1'b1, 1'b0, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF,   16'd1,      ADD,    16'h8000,   1'b0, 1'b1, 1'b0, 1'b1);
        run_op("and",       16'hF0F0,   16'hFF00,   AND,    16'hF000,   1'b0, 1'b1, 1'b0, 1'b0);
        run_op("zero",      16'h1234,   16'h5678,   ZERO,   16'h0000,   1'b1, 1'b0, 1'b0, 1'b0);
        run_op("one",       16'h1234,   16'h5678,   ONE,    16'h0001,   1'b0, 1'b0, 1'b1, 1'b0);

        // Stall: three bundles offered with the output blocked.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        chk("stall_cnt_cleared", op_count, 32'd0);
        out_ready = 1'b0;
        @(negedge clk);
        X = 16'd1; Y = 16'd2; ctrl = ADD; in_valid = 1'b1;
        chk("stall_acc_a", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        X = 16'd10; Y = 16'd20;
        chk("stall_acc_b", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        X = 16'd100; Y = 16'd1;
        chk("stall_block_c", {31'd0, in_ready}, 32'd0);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_out_a", {16'd0, out}, 32'h3);
        @(negedge clk);
        chk("stall_hold_out", {16'd0, out}, 32'h3);
        chk("stall_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_b_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_b_out", {16'd0, out}, 32'h1E);
        @(negedge clk);
        chk("drain_c_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_c_out", {16'd0, out}, 32'h65);
        @(negedge clk);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_op_count", op_count, 32'd3);

        // Reset with both stages full.
        out_ready = 1'b0;
        X = 16'd7; Y = 16'd8; ctrl = ADD; in_valid = 1'b1;
        @(negedge clk);
        X = 16'd9; Y = 16'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_op_count", op_count, 32'd0);
        chk("arst_out", {16'd0, out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        run_op("post_rst_add", 16'd1, 16'd1, ADD, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
